// File: rtl/bus_xfer_ctrl_pkg.sv
// Shared encodings and size defaults for the bus transfer controller.
package bus_xfer_ctrl_pkg;

    localparam int W_DEF    = 16;
    localparam int NREG_DEF = 8;

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOADI = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_LOAD  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/bus_xfer_ctrl_onehot_dec.sv
// Index to one-hot decoder with enable; indices >= N decode to all zero.
module onehot_dec #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic          en,
    input  logic [IW-1:0] idx,
    output logic [N-1:0]  y
);

    always_comb begin
        y = '0;
        for (int i = 0; i < N; i++) begin
            y[i] = en && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Shared-bus transfer controller: sequences MOVE/LOADI/READ through
// drive and load phases and returns a single completion response.
module bus_xfer_ctrl
    import bus_xfer_ctrl_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NREG = NREG_DEF,
    localparam int IW  = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [IW-1:0]   cmd_src,
    input  logic [IW-1:0]   cmd_dst,
    input  logic [W-1:0]    cmd_imm,
    output logic [NREG-1:0] t_en,
    output logic [NREG-1:0] ld_en,
    output logic            imm_oe,
    output logic [W-1:0]    imm_out,
    input  logic [W-1:0]    bus_in,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_data,
    output logic            rsp_err
);

    state_e        state;
    op_e           op_q;
    logic [IW-1:0] src_q;
    logic [IW-1:0] dst_q;
    logic          t_act;
    logic          ld_act;

    op_e  op_in;
    logic src_bad;
    logic dst_bad;
    logic cmd_bad;

    assign op_in = op_e'(cmd_op);

    // Out-of-range indices only exist when NREG is not a power of two.
    if (NREG == (1 << IW)) begin : g_pow2
        assign src_bad = 1'b0;
        assign dst_bad = 1'b0;
    end else begin : g_npow2
        assign src_bad = (cmd_src >= IW'(NREG));
        assign dst_bad = (cmd_dst >= IW'(NREG));
    end

    assign cmd_bad = (op_in == OP_RSVD)
                  || ((op_in != OP_LOADI) && src_bad)
                  || ((op_in != OP_READ) && dst_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_MOVE;
            src_q     <= '0;
            dst_q     <= '0;
            t_act     <= 1'b0;
            ld_act    <= 1'b0;
            imm_oe    <= 1'b0;
            imm_out   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        op_q      <= op_in;
                        src_q     <= cmd_src;
                        dst_q     <= cmd_dst;
                        rsp_data  <= '0;
                        if (cmd_bad) begin
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            rsp_err <= 1'b0;
                            t_act   <= (op_in != OP_LOADI);
                            imm_oe  <= (op_in == OP_LOADI);
                            imm_out <= (op_in == OP_LOADI) ? cmd_imm : '0;
                            state   <= ST_DRIVE;
                        end
                    end
                end
                ST_DRIVE: begin
                    ld_act <= (op_q != OP_READ);
                    state  <= ST_LOAD;
                end
                ST_LOAD: begin
                    t_act     <= 1'b0;
                    ld_act    <= 1'b0;
                    imm_oe    <= 1'b0;
                    imm_out   <= '0;
                    rsp_valid <= 1'b1;
                    if (op_q == OP_READ) begin
                        rsp_data <= bus_in;
                    end
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    onehot_dec #(.N(NREG), .IW(IW)) u_t_dec (
        .en  (t_act),
        .idx (src_q),
        .y   (t_en)
    );

    onehot_dec #(.N(NREG), .IW(IW)) u_ld_dec (
        .en  (ld_act),
        .idx (dst_q),
        .y   (ld_en)
    );

endmodule

// File: doc/bus_xfer_ctrl.md
BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

Interface
REQ-001 SHALL have parameter W, default 16, meaning bus/register data width.
REQ-002 SHALL have parameter NREG, default 8, meaning number of registers on the shared bus.
REQ-003 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports: cmd_valid  input  1  command offered; cmd_ready  output  1  command accepted when both high.
REQ-006 SHALL have ports: cmd_op  input  2  00 MOVE, 01 LOADI, 10 READ, 11 reserved.
REQ-007 SHALL have ports: cmd_src, cmd_dst  input  clog2(NREG) each  source / destination register index.
REQ-008 SHALL have ports: cmd_imm  input  W  immediate for LOADI.
REQ-009 SHALL have ports: t_en  output  NREG  one-hot transfer strobes (register drives bus).
REQ-010 SHALL have ports: ld_en  output  NREG  one-hot load strobes (register captures bus).
REQ-011 SHALL have ports: imm_oe  output  1, imm_out  output  W  controller drives immediate onto bus.
REQ-012 SHALL have ports: bus_in  input  W  sampled shared-bus value.
REQ-013 SHALL have ports: rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  W, rsp_err  output  1  completion response.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, LOAD, DONE.
REQ-015 SHALL assert cmd_ready only in IDLE; command, src, dst, imm latched on handshake; next state DRIVE.
REQ-016 DRIVE (1 cycle): MOVE/READ assert t_en[src]; LOADI asserts imm_oe with imm_out = latched imm; ld_en all zero; next LOAD.
REQ-017 LOAD (1 cycle): keep DRIVE's bus driver asserted; MOVE/LOADI assert ld_en[dst]; READ asserts no ld_en and captures bus_in into rsp_data; next DONE.
REQ-018 DONE: all strobes zero, rsp_valid=1, rsp_data/rsp_err held stable until rsp_valid&&rsp_ready, then IDLE.
REQ-019 Reserved op SHALL skip DRIVE/LOAD: IDLE -> DONE directly with rsp_err=1, no strobes asserted.
REQ-020 rsp_data SHALL be 0 for MOVE, LOADI, reserved; rsp_err SHALL be 0 for valid ops.
REQ-021 Latency: handshake cycle N -> rsp_valid at N+3 (valid ops), N+1 (reserved); minimum 4 cycles per command with rsp_ready tied high.
REQ-022 At most one of {t_en bits, imm_oe} SHALL be high in any cycle; at most one ld_en bit high in any cycle.
REQ-023 MOVE with src==dst SHALL execute normally (t_en and ld_en same index in LOAD).
REQ-024 Index >= NREG SHALL be treated as reserved: rsp_err=1, no strobes.
REQ-025 cmd_* inputs SHALL be ignored outside the handshake cycle; changes mid-operation have no effect.

Reset
REQ-026 On rst high at a clock edge: state IDLE, t_en=0, ld_en=0, imm_oe=0, imm_out=0, rsp_valid=0, rsp_data=0, rsp_err=0, cmd_ready=1 from the following cycle.
REQ-027 Reset mid-operation SHALL abort the command with no further strobes and no response.

Structure
REQ-028 Shared package SHALL hold op encodings, FSM state encoding, W and NREG defaults.
REQ-029 One sub-module onehot_dec (index -> NREG one-hot with enable) SHALL generate t_en and ld_en.

Verification
REQ-030 MOVE src=2 dst=5, bus_in=16'hBEEF -> t_en=8'h04 in DRIVE and LOAD, ld_en=8'h20 in LOAD only, rsp_valid at N+3, rsp_err=0.
REQ-031 LOADI dst=7 imm=16'h1234 -> imm_oe=1, imm_out=16'h1234 two cycles, ld_en=8'h80 in LOAD, t_en=0 throughout.
REQ-032 READ src=3, bus_in=16'hA5A5 in LOAD -> rsp_data=16'hA5A5, ld_en=0 throughout.
REQ-033 op=11 -> rsp_valid at N+1, rsp_err=1, no strobes; rsp_ready held low 5 cycles -> rsp held, cmd_ready=0.
REQ-034 rst asserted in LOAD of a MOVE -> all strobes 0 next cycle, no rsp_valid, next command accepted normally.
REQ-035 Back-to-back MOVE commands, rsp_ready=1 -> one accepted every 4 cycles; exclusivity (REQ-022) checked every cycle.
